// File: rtl/verilog_cmt_pkg.sv
// Shared state encoding and character constants for the comment stripper.
// STRING/STR_ESC exist only when COMMENT_STRIP_STRING_EN is defined.
package verilog_cmt_pkg;

  typedef enum logic [2:0] {
    CODE      = 3'd0,
    SLASH     = 3'd1,
    LINE      = 3'd2,
    BLOCK     = 3'd3,
    BLK_SLASH = 3'd4,
    BLK_STAR  = 3'd5
`ifdef COMMENT_STRIP_STRING_EN
    ,
    STRING    = 3'd6,
    STR_ESC   = 3'd7
`endif
  } state_t;

  localparam logic [7:0] CH_SLASH  = 8'h2F;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_NL     = 8'h0A;
  localparam logic [7:0] CH_DQUOTE = 8'h22;
  localparam logic [7:0] CH_BSLASH = 8'h5C;

endpackage

// File: rtl/cmt_out_buf.sv
// Output register plus one pending byte; absorbs 0-2 bytes per accepted input.
module cmt_out_buf (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [1:0] i_n,
  input  logic [7:0] i_b0,
  input  logic       i_l0,
  input  logic [7:0] i_b1,
  input  logic       i_l1,
  input  logic       i_out_ready,
  output logic       o_in_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_last
);

  logic       r_out_v;
  logic [7:0] r_out_d;
  logic       r_out_l;
  logic       r_pend_v;
  logic [7:0] r_pend_d;
  logic       r_pend_l;

  // A push can only happen when the output slot is free or draining this cycle.
  assign o_in_ready = !r_pend_v && (!r_out_v || i_out_ready);
  assign o_valid    = r_out_v;
  assign o_data     = r_out_d;
  assign o_last     = r_out_l;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_v  <= 1'b0;
      r_out_d  <= 8'h00;
      r_out_l  <= 1'b0;
      r_pend_v <= 1'b0;
      r_pend_d <= 8'h00;
      r_pend_l <= 1'b0;
    end else if (i_push) begin
      if (i_n != 2'd0) begin
        r_out_v <= 1'b1;
        r_out_d <= i_b0;
        r_out_l <= i_l0;
      end else if (i_out_ready) begin
        r_out_v <= 1'b0;
      end
      if (i_n == 2'd2) begin
        r_pend_v <= 1'b1;
        r_pend_d <= i_b1;
        r_pend_l <= i_l1;
      end
    end else if (r_out_v && i_out_ready) begin
      if (r_pend_v) begin
        r_out_d  <= r_pend_d;
        r_out_l  <= r_pend_l;
        r_pend_v <= 1'b0;
      end else begin
        r_out_v <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/verilog_comment_stripper.sv
// Streaming Verilog comment remover: drops // comments, collapses /* */ to one fill byte.
// Define COMMENT_STRIP_STRING_EN to pass "..." literals through untouched.
module verilog_comment_stripper
  import verilog_cmt_pkg::*;
#(
  parameter int         CNT_W      = 16,
  parameter logic [7:0] BLOCK_FILL = 8'h20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             err_nest,
  output logic             err_unterm,
  output logic [CNT_W-1:0] cmt_count
);

  state_t           r_state;
  logic             r_err_nest;
  logic             r_err_unterm;
  logic [CNT_W-1:0] r_cnt;

  state_t     w_next;
  state_t     w_after_code;
  logic [1:0] w_n;
  logic [7:0] w_b0;
  logic [7:0] w_b1;
  logic       w_l0;
  logic       w_l1;
  logic       w_inc;
  logic       w_nest;
  logic       w_unterm;
  logic       w_acc;
  logic       w_in_ready;

  assign w_acc      = in_valid && w_in_ready;
  assign in_ready   = w_in_ready;
  assign err_nest   = r_err_nest;
  assign err_unterm = r_err_unterm;
  assign cmt_count  = r_cnt;

`ifdef COMMENT_STRIP_STRING_EN
  assign w_after_code = (in_data == CH_DQUOTE) ? STRING : CODE;
`else
  assign w_after_code = CODE;
`endif

  always_comb begin
    w_next   = r_state;
    w_n      = 2'd0;
    w_b0     = in_data;
    w_b1     = in_data;
    w_l0     = 1'b0;
    w_l1     = 1'b0;
    w_inc    = 1'b0;
    w_nest   = 1'b0;
    w_unterm = 1'b0;
    case (r_state)
      CODE: begin
        if (in_data == CH_SLASH) begin
          w_next = SLASH;
        end else begin
          w_n    = 2'd1;
          w_next = w_after_code;
        end
      end
      SLASH: begin
        if (in_data == CH_SLASH) begin
          w_next = LINE;
          w_inc  = 1'b1;
        end else if (in_data == CH_STAR) begin
          w_next = BLOCK;
          w_inc  = 1'b1;
        end else begin
          // The held slash goes first, then this byte under CODE rules.
          w_n    = 2'd2;
          w_b0   = CH_SLASH;
          w_next = w_after_code;
        end
      end
      LINE: begin
        if (in_data == CH_NL) begin
          w_n    = 2'd1;
          w_next = CODE;
        end
      end
      BLOCK: begin
        if (in_data == CH_STAR)       w_next = BLK_STAR;
        else if (in_data == CH_SLASH) w_next = BLK_SLASH;
      end
      BLK_SLASH: begin
        if (in_data == CH_STAR) begin
          w_nest = 1'b1;
          w_next = BLK_STAR;
        end else if (in_data != CH_SLASH) begin
          w_next = BLOCK;
        end
      end
      BLK_STAR: begin
        if (in_data == CH_SLASH) begin
          w_n    = 2'd1;
          w_b0   = BLOCK_FILL;
          w_next = CODE;
        end else if (in_data != CH_STAR) begin
          w_next = BLOCK;
        end
      end
`ifdef COMMENT_STRIP_STRING_EN
      STRING: begin
        w_n = 2'd1;
        if (in_data == CH_DQUOTE)       w_next = CODE;
        else if (in_data == CH_BSLASH)  w_next = STR_ESC;
      end
      STR_ESC: begin
        w_n    = 2'd1;
        w_next = STRING;
      end
`endif
      default: w_next = CODE;
    endcase

    // End of file: flush a held slash, or mark the file end with a fill byte.
    if (in_last) begin
      if (w_next == SLASH) begin
        w_n  = 2'd1;
        w_b0 = CH_SLASH;
      end else if (w_n == 2'd0) begin
        w_n  = 2'd1;
        w_b0 = BLOCK_FILL;
      end
      if (w_n == 2'd2) w_l1 = 1'b1;
      else             w_l0 = 1'b1;
      w_unterm = (w_next == BLOCK) || (w_next == BLK_SLASH) || (w_next == BLK_STAR);
      w_next   = CODE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= CODE;
      r_err_nest   <= 1'b0;
      r_err_unterm <= 1'b0;
      r_cnt        <= '0;
    end else if (w_acc) begin
      r_state <= w_next;
      if (w_nest)   r_err_nest   <= 1'b1;
      if (w_unterm) r_err_unterm <= 1'b1;
      if (w_inc && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
    end
  end

  cmt_out_buf u_out_buf (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_acc),
    .i_n         (w_n),
    .i_b0        (w_b0),
    .i_l0        (w_l0),
    .i_b1        (w_b1),
    .i_l1        (w_l1),
    .i_out_ready (out_ready),
    .o_in_ready  (w_in_ready),
    .o_valid     (out_valid),
    .o_data      (out_data),
    .o_last      (out_last)
  );

endmodule
